// File: rtl/bit_shift_sequencer.sv
// Sequenced shifter/rotator: shifts a word by a runtime amount, at most STEP_BITS per clock.
// Latency: ceil(E/STEP_BITS)+1 cycles from accept to out_valid (1 cycle when E=0).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module bit_shift_sequencer #(
    parameter string ARCHITECTURE = "BEHAVIORAL",
    parameter int    DATA_WIDTH   = 8,
    parameter int    AMT_WIDTH    = 4,
    parameter int    STEP_BITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [AMT_WIDTH-1:0]  in_amt,
    input  logic                  in_dir,
    input  logic                  in_wrap,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam int SHW = $clog2(DATA_WIDTH);

    generate
        if (ARCHITECTURE == "BEHAVIORAL") begin : g_behav
            typedef enum logic [1:0] {
                IDLE  = 2'd0,
                SHIFT = 2'd1,
                DONE  = 2'd2
            } state_t;

            typedef struct packed {
                logic dir;
                logic wrap;
            } ctl_t;

            localparam logic [SHW:0] STEP   = (SHW+1)'(STEP_BITS);
            localparam logic [SHW:0] FULL_E = (SHW+1)'(DATA_WIDTH);

            state_t                  state;
            state_t                  state_nxt;
            ctl_t                    ctl;
            logic [DATA_WIDTH-1:0]   work;
            logic [SHW:0]            remaining;
            logic [SHW:0]            eff_amt;
            logic [SHW:0]            s_amt;
            logic [2*DATA_WIDTH-1:0] dbl_sh;
            logic [DATA_WIDTH-1:0]   rot_res;
            logic [DATA_WIDTH-1:0]   lin_res;
            logic [DATA_WIDTH-1:0]   step_res;
            logic                    last_step;
            logic [DATA_WIDTH-1:0]   out_data_q;

            // Rotation reduces modulo the width; a logical shift saturates at a full clear.
            always_comb begin
                eff_amt = '0;
                if (in_wrap) begin
                    eff_amt = {1'b0, in_amt[SHW-1:0]};
                end else if (in_amt >= AMT_WIDTH'(DATA_WIDTH)) begin
                    eff_amt = FULL_E;
                end else begin
                    eff_amt = in_amt[SHW:0];
                end
            end

            // One step: rotate uses a doubled word so the wrapped bits fall in naturally.
            always_comb begin
                s_amt     = (remaining > STEP) ? STEP : remaining;
                last_step = (remaining == s_amt);
                dbl_sh    = ctl.dir ? ({work, work} >> s_amt) : ({work, work} << s_amt);
                rot_res   = ctl.dir ? dbl_sh[DATA_WIDTH-1:0] : dbl_sh[2*DATA_WIDTH-1:DATA_WIDTH];
                lin_res   = ctl.dir ? (work >> s_amt) : (work << s_amt);
                step_res  = ctl.wrap ? rot_res : lin_res;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state <= IDLE;
                end else begin
                    state <= state_nxt;
                end
            end

            always_comb begin
                state_nxt = state;
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b1;
                case (state)
                    IDLE: begin
                        in_ready = 1'b1;
                        busy     = 1'b0;
                        if (in_valid) begin
                            state_nxt = (eff_amt == '0) ? DONE : SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (last_step) begin
                            state_nxt = DONE;
                        end
                    end
                    DONE: begin
                        out_valid = 1'b1;
                        if (out_ready) begin
                            state_nxt = IDLE;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase
            end

            // out_data_q is only written when a result completes, so it survives the handshake.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    work       <= '0;
                    remaining  <= '0;
                    ctl        <= '0;
                    out_data_q <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (in_valid) begin
                                work      <= in_data;
                                remaining <= eff_amt;
                                ctl       <= '{dir: in_dir, wrap: in_wrap};
                                if (eff_amt == '0) begin
                                    out_data_q <= in_data;
                                end
                            end
                        end
                        SHIFT: begin
                            work      <= step_res;
                            remaining <= remaining - s_amt;
                            if (last_step) begin
                                out_data_q <= step_res;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            assign out_data = out_data_q;
        end else begin : g_placeholder
            assign in_ready  = 1'b0;
            assign out_valid = 1'b0;
            assign out_data  = '0;
            assign busy      = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_bit_shift_sequencer.sv
// Directed bench for bit_shift_sequencer (DATA_WIDTH=8, STEP_BITS=2).
module tb_bit_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_amt;
    logic       in_dir;
    logic       in_wrap;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    bit_shift_sequencer #(
        .ARCHITECTURE("BEHAVIORAL"),
        .DATA_WIDTH  (8),
        .AMT_WIDTH   (4),
        .STEP_BITS   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .in_dir   (in_dir),
        .in_wrap  (in_wrap),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge; returns in cycle k+1.
    task automatic send(input logic [7:0] d, input logic [3:0] a, input logic dir, input logic wrap);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
        in_wrap  = wrap;
        tick();
        in_valid = 1'b0;
    endtask

    // cyc counts cycles after the accept edge until out_valid is seen (k+cyc).
    task automatic wait_valid(input int limit, output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    int         cyc;
    int         busy_cnt;
    int         stray;
    logic [7:0] held;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        in_wrap   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        // 0xB4 >> 3 logical, two steps
        send(8'hB4, 4'd3, 1'b1, 1'b0);
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 0);
        wait_valid(20, cyc);
        check("t1_latency", cyc, 3);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 8'h16);
        tick();
        check("t1_idle", in_ready, 1);

        // rotate left by 1, then amt 0
        send(8'h81, 4'd1, 1'b0, 1'b1);
        wait_valid(20, cyc);
        check("t2_latency", cyc, 2);
        check("t2_data", out_data, 8'h03);
        tick();
        send(8'h81, 4'd0, 1'b0, 1'b1);
        wait_valid(20, cyc);
        check("t2z_latency", cyc, 1);
        check("t2z_valid", out_valid, 1);
        check("t2z_data", out_data, 8'h81);
        tick();

        // logical left by 12 saturates to 8: four steps, all zeros
        send(8'hFF, 4'd12, 1'b0, 1'b0);
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 20) begin
            if (out_valid === 1'b1) check("t3_data", out_data, 8'h00);
            busy_cnt++;
            tick();
        end
        check("t3_busy_cycles", busy_cnt, 5);

        // rotate right by 11 -> 3, inputs scrambled during SHIFT
        send(8'hB4, 4'd11, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            in_data = 8'($urandom);
            in_amt  = 4'($urandom);
            in_dir  = 1'($urandom);
            in_wrap = 1'($urandom);
            tick();
        end
        check("t4_valid", out_valid, 1);
        check("t4_data", out_data, 8'h96);
        tick();

        // backpressure: result held in DONE, in_valid pulses ignored
        out_ready = 1'b0;
        send(8'h0F, 4'd4, 1'b0, 1'b0);
        wait_valid(20, cyc);
        check("t5_latency", cyc, 3);
        check("t5_data", out_data, 8'hF0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'hA5;
            in_amt   = 4'd0;
            tick();
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_data", out_data, 8'hF0);
            check("t5_hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t5_idle_ready", in_ready, 1);
        check("t5_idle_valid", out_valid, 0);
        check("t5_keep_data", out_data, 8'hF0);
        send(8'h3C, 4'd2, 1'b1, 1'b1);
        check("t5_b2b_busy", busy, 1);
        wait_valid(20, cyc);
        check("t5_b2b_latency", cyc, 2);
        check("t5_b2b_data", out_data, 8'h0F);
        tick();

        // reset in the middle of a 4-step request
        send(8'hFF, 4'd8, 1'b1, 1'b0);
        tick();
        check("t6_mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_valid", out_valid, 0);
        check("t6_data", out_data, 8'h00);
        check("t6_busy", busy, 0);
        check("t6_in_ready", in_ready, 1);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
            tick();
        end
        check("t6_no_stale", stray, 0);
        send(8'h01, 4'd7, 1'b0, 1'b1);
        wait_valid(20, cyc);
        check("t6_after_latency", cyc, 5);
        check("t6_after_data", out_data, 8'h80);
        tick();
        check("t6_after_idle", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
